regfile_write_arbiter: RTL and testbench



---
 rtl/regfile_write_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback always wins, long-latency results queue and drain on idle cycles.
// Latency: pipeline 1 cycle, long-latency 2 cycles minimum; luReady drops when the queue is full, stallRequest flags starvation.

module regfile_write_arbiter_fifo #(
   parameter int W     = 37,
   parameter int DEPTH = 2
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          push_vld,
   input  logic [W-1:0]                  push_dat,
   input  logic                          pop_vld,
   output logic [W-1:0]                  head_dat,
   output logic [$clog2(DEPTH):0]        count,
   output logic [DEPTH-1:0]              slot_vld,
   output logic [DEPTH-1:0][W-1:0]       slot_dat
);
   localparam int AW = $clog2(DEPTH);

   logic [DEPTH-1:0][W-1:0] mem;
   logic [AW-1:0]           wr_ptr;
   logic [AW-1:0]           rd_ptr;

   // Callers never push when full nor pop when empty, so the pointers never collide on a
   // simultaneous push/pop.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         slot_vld <= '0;
      end else begin
         if (push_vld) begin
            wr_ptr           <= wr_ptr + AW'(1);
            slot_vld[wr_ptr] <= 1'b1;
         end
         if (pop_vld) begin
            rd_ptr           <= rd_ptr + AW'(1);
            slot_vld[rd_ptr] <= 1'b0;
         end
         case ({push_vld, pop_vld})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (push_vld) begin
         mem[wr_ptr] <= push_dat;
      end
   end

   assign head_dat = mem[rd_ptr];
   assign slot_dat = mem;

endmodule

module regfile_write_arbiter #(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        pipeEnable,
   input  logic [4:0]  pipeAddress,
   input  logic [31:0] pipeData,
   input  logic        luValid,
   input  logic [4:0]  luAddress,
   input  logic [31:0] luData,
   output logic        luReady,
   output logic        destinationEnable,
   output logic [4:0]  writeAddress,
   output logic [31:0] writeData,
   output logic [31:0] pendingMask,
   output logic        stallRequest
);
   localparam int AW = $clog2(DEPTH);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam int EW = 37;
   localparam logic [AW:0]   FULL_CNT   = (AW+1)'(DEPTH);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } lu_entry_t;

   logic                     pipe_win;
   logic                     push;
   logic                     pop;
   logic                     fifo_empty;
   logic [AW:0]              fifo_count;
   lu_entry_t                push_entry;
   lu_entry_t                head_entry;
   lu_entry_t                slot_entry;
   logic [DEPTH-1:0]         slot_vld;
   logic [DEPTH-1:0][EW-1:0] slot_dat;
   logic                     out_is_lu;
   logic [SW-1:0]            starve_cnt;
   logic [SW-1:0]            starve_nxt;
   logic [31:0]              mask;

   assign pipe_win   = pipeEnable && (pipeAddress != 5'd0);
   assign luReady    = (fifo_count < FULL_CNT);
   assign fifo_empty = (fifo_count == '0);
   // Writes to r0 still handshake so the long-latency unit never blocks on them.
   assign push       = luValid && luReady && (luAddress != 5'd0);
   assign pop        = !pipe_win && !fifo_empty;
   assign push_entry = '{addr: luAddress, data: luData};

   regfile_write_arbiter_fifo #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .push_vld (push),
      .push_dat (push_entry),
      .pop_vld  (pop),
      .head_dat (head_entry),
      .count    (fifo_count),
      .slot_vld (slot_vld),
      .slot_dat (slot_dat)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         destinationEnable <= 1'b0;
         writeAddress      <= '0;
         writeData         <= '0;
         out_is_lu         <= 1'b0;
      end else if (pipe_win) begin
         destinationEnable <= 1'b1;
         writeAddress      <= pipeAddress;
         writeData         <= pipeData;
         out_is_lu         <= 1'b0;
      end else if (pop) begin
         destinationEnable <= 1'b1;
         writeAddress      <= head_entry.addr;
         writeData         <= head_entry.data;
         out_is_lu         <= 1'b1;
      end else begin
         destinationEnable <= 1'b0;
         out_is_lu         <= 1'b0;
      end
   end

   // A non-empty queue either drains or loses to the pipeline, so the counter
   // measures consecutive losses of the current head.
   always_comb begin
      starve_nxt = starve_cnt;
      if (pop || fifo_empty) begin
         starve_nxt = '0;
      end else if (pipe_win && (starve_cnt != STARVE_MAX)) begin
         starve_nxt = starve_cnt + SW'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         starve_cnt   <= '0;
         stallRequest <= 1'b0;
      end else begin
         starve_cnt <= starve_nxt;
         if (pop) begin
            stallRequest <= 1'b0;
         end else if (starve_nxt == STARVE_MAX) begin
            stallRequest <= 1'b1;
         end
      end
   end

   always_comb begin
      mask       = '0;
      slot_entry = '0;
      for (int i = 0; i < DEPTH; i++) begin
         slot_entry = slot_dat[i];
         if (slot_vld[i]) begin
            mask[slot_entry.addr] = 1'b1;
         end
      end
      if (destinationEnable && out_is_lu) begin
         mask[writeAddress] = 1'b1;
      end
      mask[0]     = 1'b0;
      pendingMask = mask;
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with hand-computed expectations.

module tb_regfile_write_arbiter;
   logic        clock = 1'b0;
   logic        reset;
   logic        pipeEnable;
   logic [4:0]  pipeAddress;
   logic [31:0] pipeData;
   logic        luValid;
   logic [4:0]  luAddress;
   logic [31:0] luData;
   logic        luReady;
   logic        destinationEnable;
   logic [4:0]  writeAddress;
   logic [31:0] writeData;
   logic [31:0] pendingMask;
   logic        stallRequest;

   int vectors     = 0;
   int miscompares = 0;

   regfile_write_arbiter #(
      .DEPTH        (2),
      .STARVE_LIMIT (4)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .pipeEnable        (pipeEnable),
      .pipeAddress       (pipeAddress),
      .pipeData          (pipeData),
      .luValid           (luValid),
      .luAddress         (luAddress),
      .luData            (luData),
      .luReady           (luReady),
      .destinationEnable (destinationEnable),
      .writeAddress      (writeAddress),
      .writeData         (writeData),
      .pendingMask       (pendingMask),
      .stallRequest      (stallRequest)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic en, input logic [4:0] addr, input logic [31:0] data);
      chk({tag, ".en"}, 32'(destinationEnable), 32'(en));
      chk({tag, ".addr"}, 32'(writeAddress), 32'(addr));
      chk({tag, ".data"}, writeData, data);
   endtask

   initial begin
      reset       = 1'b1;
      pipeEnable  = 1'b0;
      pipeAddress = '0;
      pipeData    = '0;
      luValid     = 1'b0;
      luAddress   = '0;
      luData      = '0;
      #12;
      chk_out("rst", 1'b0, 5'd0, 32'h0);
      chk("rst.ready", 32'(luReady), 32'd1);
      chk("rst.mask", pendingMask, 32'h0);
      chk("rst.stall", 32'(stallRequest), 32'd0);
      tick();
      reset = 1'b0;

      // Pipeline write, then idle hold, then discarded r0 write
      pipeEnable = 1'b1; pipeAddress = 5'd5; pipeData = 32'hDEADBEEF;
      tick();
      chk_out("pipe5", 1'b1, 5'd5, 32'hDEADBEEF);
      pipeEnable = 1'b0;
      tick();
      chk_out("pipe5.next", 1'b0, 5'd5, 32'hDEADBEEF);
      pipeEnable = 1'b1; pipeAddress = 5'd0; pipeData = 32'h00001234;
      tick();
      chk_out("pipe0", 1'b0, 5'd5, 32'hDEADBEEF);
      pipeEnable = 1'b0;

      // Long-latency r7 then r9 with idle pipeline
      luValid = 1'b1; luAddress = 5'd7; luData = 32'h11;
      chk("lu.ready0", 32'(luReady), 32'd1);
      tick();
      chk("lu.mask1", pendingMask, 32'h0000_0080);
      chk("lu.en1", 32'(destinationEnable), 32'd0);
      luAddress = 5'd9; luData = 32'h22;
      tick();
      chk_out("lu.r7", 1'b1, 5'd7, 32'h11);
      chk("lu.mask2", pendingMask, 32'h0000_0280);
      luValid = 1'b0;
      tick();
      chk_out("lu.r9", 1'b1, 5'd9, 32'h22);
      chk("lu.mask3", pendingMask, 32'h0000_0200);
      tick();
      chk("lu.en4", 32'(destinationEnable), 32'd0);
      chk("lu.mask4", pendingMask, 32'h0);

      // Busy pipeline fills the queue; third result back-pressured
      pipeEnable = 1'b1; pipeAddress = 5'd1; pipeData = 32'hA0;
      luValid = 1'b1; luAddress = 5'd3; luData = 32'h33;
      tick();
      chk_out("bp.p1", 1'b1, 5'd1, 32'hA0);
      pipeAddress = 5'd2; pipeData = 32'hA1;
      luAddress = 5'd4; luData = 32'h44;
      tick();
      chk("bp.ready_full", 32'(luReady), 32'd0);
      chk("bp.mask_full", pendingMask, 32'h0000_0018);
      pipeAddress = 5'd1; pipeData = 32'hA2;
      luAddress = 5'd6; luData = 32'h66;
      tick();
      chk_out("bp.p3", 1'b1, 5'd1, 32'hA2);
      chk("bp.ready_still", 32'(luReady), 32'd0);
      chk("bp.mask_still", pendingMask, 32'h0000_0018);
      pipeEnable = 1'b0;
      tick();
      chk_out("bp.r3", 1'b1, 5'd3, 32'h33);
      chk("bp.ready_up", 32'(luReady), 32'd1);
      tick();
      chk_out("bp.r4", 1'b1, 5'd4, 32'h44);
      chk("bp.mask_r6", pendingMask, 32'h0000_0050);
      luValid = 1'b0;
      tick();
      chk_out("bp.r6", 1'b1, 5'd6, 32'h66);
      chk("bp.mask_last", pendingMask, 32'h0000_0040);
      chk("bp.stall", 32'(stallRequest), 32'd0);
      tick();
      chk("bp.idle", 32'(destinationEnable), 32'd0);
      chk("bp.mask_clear", pendingMask, 32'h0);

      // Starvation: one buffered entry loses four times in a row
      pipeEnable = 1'b1; pipeAddress = 5'd10; pipeData = 32'hB0;
      luValid = 1'b1; luAddress = 5'd12; luData = 32'hCC;
      tick();
      luValid = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         pipeData = 32'hB0 + 32'(k);
         tick();
         chk("st.no_stall", 32'(stallRequest), 32'd0);
      end
      pipeData = 32'hB4;
      tick();
      chk("st.stall_on", 32'(stallRequest), 32'd1);
      chk_out("st.p4", 1'b1, 5'd10, 32'hB4);
      pipeData = 32'hB5;
      tick();
      chk("st.stall_hold", 32'(stallRequest), 32'd1);
      chk_out("st.p5", 1'b1, 5'd10, 32'hB5);
      pipeEnable = 1'b0;
      tick();
      chk_out("st.r12", 1'b1, 5'd12, 32'hCC);
      chk("st.stall_off", 32'(stallRequest), 32'd0);
      tick();

      // r0 long-latency result: handshake only
      luValid = 1'b1; luAddress = 5'd0; luData = 32'h55;
      chk("z.ready", 32'(luReady), 32'd1);
      tick();
      luValid = 1'b0;
      chk("z.mask", pendingMask, 32'h0);
      chk("z.ready_after", 32'(luReady), 32'd1);
      tick();
      chk("z.no_write", 32'(destinationEnable), 32'd0);

      // Asynchronous reset with two buffered entries
      pipeEnable = 1'b1; pipeAddress = 5'd2; pipeData = 32'hC0;
      luValid = 1'b1; luAddress = 5'd20; luData = 32'h20;
      tick();
      luAddress = 5'd21; luData = 32'h21;
      tick();
      chk("ar.ready_full", 32'(luReady), 32'd0);
      chk("ar.mask_full", pendingMask, 32'h0030_0000);
      #2;
      reset = 1'b1;
      #1;
      chk_out("ar", 1'b0, 5'd0, 32'h0);
      chk("ar.ready", 32'(luReady), 32'd1);
      chk("ar.mask", pendingMask, 32'h0);
      chk("ar.stall", 32'(stallRequest), 32'd0);
      pipeEnable = 1'b0; luValid = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      chk("ar.no_drain", 32'(destinationEnable), 32'd0);
      chk("ar.mask_after", pendingMask, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
